// File: rtl/mult_rev_pkg.sv
// Shared types and constants for the reversible multiplier/divider.
package mult_rev_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mr_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

endpackage

// File: rtl/mult_rev_step.sv
// One iteration of the reversible datapath.
// Forward: add A<<iter to the accumulator when the current B bit is set.
// Backward: restoring-division step. Shift the next P bit into the partial
// remainder, trial-subtract A and report the resulting quotient bit.
module mult_rev_step
    import mult_rev_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic               dir,
    input  logic [CW-1:0]      iter,
    input  logic [WIDTH-1:0]   a,
    input  logic               mul_bit,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   prem,
    input  logic               p_bit,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0]   prem_nxt,
    output logic               q_bit
);

    logic [WIDTH:0]     shifted;
    logic [2*WIDTH-1:0] addend;

    // The partial remainder is always below A between iterations, so it is
    // kept as W bits and only widened to W+1 while the next P bit is shifted in.
    assign shifted = {prem, p_bit};
    assign addend  = {{WIDTH{1'b0}}, a} << iter;

    // Select add-or-skip or subtract-or-restore based on direction.
    always_comb begin
        acc_nxt  = acc;
        prem_nxt = prem;
        q_bit    = 1'b0;
        if (dir == DIR_FWD) begin
            if (mul_bit) begin
                acc_nxt = acc + addend;
            end
        end else begin
            if (shifted >= {1'b0, a}) begin
                prem_nxt = WIDTH'(shifted - {1'b0, a});
                q_bit    = 1'b1;
            end else begin
                prem_nxt = shifted[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mult_rev_seq.sv
// Sequential reversible multiplier/divider.
// Forward: P = A*B by shift-add. Backward: B = P/A by restoring division,
// also returning A, the remainder and the upper half of P.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ST_IDLE | waiting for an operand; in_ready high (except the first
//          | cycle after reset)
//  ST_BUSY | W iterations (cnt 0..W-1), then one cycle to load outputs
//  ST_DONE | result presented with out_valid; held until out_ready
module mult_rev_seq
    import mult_rev_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dir,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2*WIDTH-1:0] in_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_dir,
    output logic [2*WIDTH-1:0] out_p,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic [WIDTH-1:0]   out_extra,
    output logic [WIDTH-1:0]   out_rem,
    output logic               out_err
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ITER_END = CW'(WIDTH);

    mr_state_t          state;
    logic [CW-1:0]      cnt;
    logic               dir_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   p_lo;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   prem;
    logic [WIDTH-1:0]   extra_r;
    logic               err_r;

    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   prem_nxt;
    logic               q_bit;

    // b_r holds B shifted right in forward mode (bit 0 is the current
    // multiplier bit) and collects quotient bits from the right in backward mode.
    mult_rev_step #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_step (
        .dir      (dir_r),
        .iter     (cnt),
        .a        (a_r),
        .mul_bit  (b_r[0]),
        .acc      (acc),
        .prem     (prem),
        .p_bit    (p_lo[WIDTH-1]),
        .acc_nxt  (acc_nxt),
        .prem_nxt (prem_nxt),
        .q_bit    (q_bit)
    );

    // Control FSM, iteration registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dir_r     <= DIR_FWD;
            a_r       <= '0;
            b_r       <= '0;
            p_lo      <= '0;
            acc       <= '0;
            prem      <= '0;
            extra_r   <= '0;
            err_r     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_dir   <= 1'b0;
            out_p     <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_extra <= '0;
            out_rem   <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        state    <= ST_BUSY;
                        cnt      <= '0;
                        dir_r    <= dir;
                        a_r      <= in_a;
                        b_r      <= (dir == DIR_FWD) ? in_b : '0;
                        p_lo     <= in_p[WIDTH-1:0];
                        acc      <= '0;
                        prem     <= in_p[2*WIDTH-1:WIDTH];
                        extra_r  <= in_p[2*WIDTH-1:WIDTH];
                        // A quotient only fits in W bits when P's upper half is below A.
                        err_r    <= (dir == DIR_BWD) &&
                                    ((in_a == '0) || (in_p[2*WIDTH-1:WIDTH] >= in_a));
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                ST_BUSY: begin
                    if (cnt != ITER_END) begin
                        acc  <= acc_nxt;
                        prem <= prem_nxt;
                        b_r  <= (dir_r == DIR_FWD) ? (b_r >> 1)
                                                   : {b_r[WIDTH-2:0], q_bit};
                        p_lo <= {p_lo[WIDTH-2:0], 1'b0};
                        cnt  <= cnt + 1'b1;
                    end else begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out_dir   <= dir_r;
                        out_a     <= a_r;
                        if (dir_r == DIR_FWD) begin
                            out_p     <= acc;
                            out_b     <= '0;
                            out_extra <= '0;
                            out_rem   <= '0;
                            out_err   <= 1'b0;
                        end else begin
                            out_p     <= '0;
                            out_b     <= err_r ? '0 : b_r;
                            out_extra <= extra_r;
                            out_rem   <= err_r ? '0 : prem;
                            out_err   <= err_r;
                        end
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rev_seq.sv
// Testbench for mult_rev_seq (WIDTH=8): directed vectors, backpressure,
// reset during an operation and randomized traffic against an arithmetic model.
module tb_mult_rev_seq;

    localparam int W   = 8;
    localparam int LAT = W + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           dir = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic [2*W-1:0] in_p = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           out_dir;
    logic [2*W-1:0] out_p;
    logic [W-1:0]   out_a;
    logic [W-1:0]   out_b;
    logic [W-1:0]   out_extra;
    logic [W-1:0]   out_rem;
    logic           out_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic           dir;
        logic [2*W-1:0] p;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   extra;
        logic [W-1:0]   rem;
        logic           err;
    } res_t;

    mult_rev_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dir       (dir),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_p      (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dir   (out_dir),
        .out_p     (out_p),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_extra (out_extra),
        .out_rem   (out_rem),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer multiply / divide.
    function automatic res_t model(input logic d, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [2*W-1:0] p);
        res_t r;
        logic [W-1:0] hi;
        r.dir = d; r.a = a; r.p = '0; r.b = '0; r.extra = '0; r.rem = '0; r.err = 1'b0;
        if (d == 1'b0) begin
            r.p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end else begin
            hi      = p[2*W-1:W];
            r.extra = hi;
            r.err   = (a == 0) || (hi >= a);
            if (!r.err) begin
                r.b   = W'(p / {{W{1'b0}}, a});
                r.rem = W'(p % {{W{1'b0}}, a});
            end
        end
        return r;
    endfunction

    // Drive one operation (called at a negedge), wait for the result and
    // optionally complete the output handshake. lat = edges from accept to out_valid.
    task automatic run_op(input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] p, input bit release_out,
                          output res_t got, output int lat);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        dir = d; in_a = a; in_b = b; in_p = p; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom); in_p = (2*W)'($urandom); dir = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got.dir = out_dir; got.p = out_p; got.a = out_a; got.b = out_b;
        got.extra = out_extra; got.rem = out_rem; got.err = out_err;
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({in_ready, out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_handshake got in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
        end
        n_tests++;
        if ({out_p, out_a, out_b, out_extra, out_rem, out_err, out_dir} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got p=%h a=%h b=%h x=%h r=%h e=%b d=%b want all 0",
                     out_p, out_a, out_b, out_extra, out_rem, out_err, out_dir);
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready got %b want 1", in_ready);
        end
    endtask

    logic           vd [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [W-1:0]   va [7] = '{8'h12, 8'h08, 8'hFF, 8'h12, 8'h08, 8'h12, 8'h00};
    logic [W-1:0]   vb [7] = '{8'h04, 8'h11, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [2*W-1:0] vp [7] = '{16'h0, 16'h0, 16'h0, 16'h0048, 16'h0089, 16'h8C40, 16'h1234};
    logic [2*W-1:0] ep [7] = '{16'h0048, 16'h0088, 16'hFE01, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [W-1:0]   eb [7] = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h00, 8'h00};
    logic [W-1:0]   er [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    logic [W-1:0]   ex [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h8C, 8'h12};
    logic           ee [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic test_directed();
        res_t got;
        int   lat;
        for (int i = 0; i < 7; i++) begin
            run_op(vd[i], va[i], vb[i], vp[i], 1'b1, got, lat);
            n_tests++;
            if (lat !== LAT) begin
                n_fail++;
                $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, LAT);
            end
            n_tests++;
            if (got.p !== ep[i] || got.a !== va[i] || got.dir !== vd[i]) begin
                n_fail++;
                $display("FAIL dir_p_a[%0d] got p=%h a=%h d=%b want p=%h a=%h d=%b",
                         i, got.p, got.a, got.dir, ep[i], va[i], vd[i]);
            end
            n_tests++;
            if (got.b !== eb[i] || got.rem !== er[i] || got.extra !== ex[i] || got.err !== ee[i]) begin
                n_fail++;
                $display("FAIL dir_b_rem[%0d] got b=%h r=%h x=%h e=%b want b=%h r=%h x=%h e=%b",
                         i, got.b, got.rem, got.extra, got.err, eb[i], er[i], ex[i], ee[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        res_t got;
        res_t exp;
        int   lat;
        exp = model(1'b0, 8'h5A, 8'h3C, 16'h0);
        run_op(1'b0, 8'h5A, 8'h3C, 16'h0, 1'b0, got, lat);
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_p !== exp.p || out_a !== 8'h5A) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b rdy=%b p=%h a=%h want v=1 rdy=0 p=%h a=5a",
                         c, out_valid, in_ready, out_p, out_a, exp.p);
            end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_p !== exp.p) begin
            n_fail++;
            $display("FAIL bp_release got v=%b rdy=%b p=%h want v=0 rdy=1 p=%h",
                     out_valid, in_ready, out_p, exp.p);
        end
    endtask

    task automatic test_reset_mid_busy();
        res_t got;
        int   lat;
        dir = 1'b0; in_a = 8'hAB; in_b = 8'hCD; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready, out_p, out_a, out_b, out_extra, out_rem, out_err, out_dir} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got v=%b rdy=%b p=%h a=%h b=%h want all 0",
                     out_valid, in_ready, out_p, out_a, out_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 8'h03, 8'h05, 16'h0, 1'b1, got, lat);
        n_tests++;
        if (got.p !== 16'h000F || lat !== LAT || got.err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_op got p=%h lat=%0d e=%b want p=000f lat=%0d e=0",
                     got.p, lat, got.err, LAT);
        end
    endtask

    task automatic test_random();
        res_t           got;
        res_t           exp;
        int             lat;
        logic           d;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        for (int i = 0; i < 40; i++) begin
            d = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            if (d && a != 0 && $urandom_range(0, 2) != 0)
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b} + (2*W)'($urandom_range(0, int'(a) - 1));
            else
                p = (2*W)'($urandom);
            exp = model(d, a, b, p);
            run_op(d, a, b, p, 1'b1, got, lat);
            n_tests++;
            if (lat !== LAT || got.dir !== exp.dir || got.p !== exp.p || got.a !== exp.a ||
                got.b !== exp.b || got.extra !== exp.extra || got.rem !== exp.rem || got.err !== exp.err) begin
                n_fail++;
                $display("FAIL rand[%0d] in d=%b a=%h b=%h p=%h got lat=%0d p=%h a=%h b=%h x=%h r=%h e=%b want lat=%0d p=%h a=%h b=%h x=%h r=%h e=%b",
                         i, d, a, b, p, lat, got.p, got.a, got.b, got.extra, got.rem, got.err,
                         LAT, exp.p, exp.a, exp.b, exp.extra, exp.rem, exp.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
